// File: rtl/dest_reg_if.sv
// Decode-side inputs and pipeline-register metadata outputs of dest_reg_pipeline.
// The decoder/forwarding side uses the master modport, and the pipeline uses the slave modport.
interface dest_reg_if #(
  parameter int CNT_W = 16
);
  logic [3:0]       ID_SrcReg1;
  logic [3:0]       ID_SrcReg2;
  logic [3:0]       ID_reg_rd;
  logic             ID_Uses1;
  logic             ID_Uses2;
  logic             ID_RegWrite;
  logic             ID_MemRead;
  logic             ID_MemWrite;
  logic             Flush;

  logic [3:0]       ID_EX_SrcReg1;
  logic [3:0]       ID_EX_SrcReg2;
  logic [3:0]       ID_EX_reg_rd;
  logic             ID_EX_RegWrite;
  logic             ID_EX_MemRead;
  logic             ID_EX_MemWrite;
  logic [3:0]       EX_MEM_SrcReg2;
  logic [3:0]       EX_MEM_reg_rd;
  logic             EX_MEM_RegWrite;
  logic             EX_MEM_MemRead;
  logic [3:0]       MEM_WB_reg_rd;
  logic             MEM_WB_RegWrite;
  logic             Stall;
  logic [CNT_W-1:0] stall_count;
  logic [CNT_W-1:0] flush_count;

  modport master (
    output ID_SrcReg1, ID_SrcReg2, ID_reg_rd, ID_Uses1, ID_Uses2,
           ID_RegWrite, ID_MemRead, ID_MemWrite, Flush,
    input  ID_EX_SrcReg1, ID_EX_SrcReg2, ID_EX_reg_rd,
           ID_EX_RegWrite, ID_EX_MemRead, ID_EX_MemWrite,
           EX_MEM_SrcReg2, EX_MEM_reg_rd, EX_MEM_RegWrite, EX_MEM_MemRead,
           MEM_WB_reg_rd, MEM_WB_RegWrite, Stall, stall_count, flush_count
  );

  modport slave (
    input  ID_SrcReg1, ID_SrcReg2, ID_reg_rd, ID_Uses1, ID_Uses2,
           ID_RegWrite, ID_MemRead, ID_MemWrite, Flush,
    output ID_EX_SrcReg1, ID_EX_SrcReg2, ID_EX_reg_rd,
           ID_EX_RegWrite, ID_EX_MemRead, ID_EX_MemWrite,
           EX_MEM_SrcReg2, EX_MEM_reg_rd, EX_MEM_RegWrite, EX_MEM_MemRead,
           MEM_WB_reg_rd, MEM_WB_RegWrite, Stall, stall_count, flush_count
  );
endinterface

// File: rtl/dest_reg_pipeline.sv
// Carries register-ID/write-control metadata through ID/EX, EX/MEM and MEM/WB,
// detects load-use hazards against decode, and counts stalls and flushes.
module dest_reg_pipeline #(
  parameter int CNT_W = 16
) (
  input logic       clk,
  input logic       rst,
  dest_reg_if.slave bus
);

  logic [3:0]       id_ex_src1_q;
  logic [3:0]       id_ex_src2_q;
  logic [3:0]       id_ex_rd_q;
  logic             id_ex_regwrite_q;
  logic             id_ex_memread_q;
  logic             id_ex_memwrite_q;
  logic [3:0]       ex_mem_src2_q;
  logic [3:0]       ex_mem_rd_q;
  logic             ex_mem_regwrite_q;
  logic             ex_mem_memread_q;
  logic [3:0]       mem_wb_rd_q;
  logic             mem_wb_regwrite_q;
  logic [CNT_W-1:0] stall_count_q;
  logic [CNT_W-1:0] flush_count_q;

  logic hit_src1;
  logic hit_src2;
  logic load_use;
  logic stall;
  logic bubble;

  // A store reading the loaded register only as data is served by MEM-to-MEM
  // forwarding, so that match alone does not stall.
  always_comb begin
    hit_src1 = bus.ID_Uses1 && (id_ex_rd_q == bus.ID_SrcReg1);
    hit_src2 = bus.ID_Uses2 && (id_ex_rd_q == bus.ID_SrcReg2) && !bus.ID_MemWrite;
    load_use = id_ex_memread_q && (id_ex_rd_q != 4'd0) && (hit_src1 || hit_src2);
    stall    = load_use && !bus.Flush;
    bubble   = stall || bus.Flush;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id_ex_src1_q      <= 4'd0;
      id_ex_src2_q      <= 4'd0;
      id_ex_rd_q        <= 4'd0;
      id_ex_regwrite_q  <= 1'b0;
      id_ex_memread_q   <= 1'b0;
      id_ex_memwrite_q  <= 1'b0;
      ex_mem_src2_q     <= 4'd0;
      ex_mem_rd_q       <= 4'd0;
      ex_mem_regwrite_q <= 1'b0;
      ex_mem_memread_q  <= 1'b0;
      mem_wb_rd_q       <= 4'd0;
      mem_wb_regwrite_q <= 1'b0;
    end else begin
      if (bubble) begin
        id_ex_src1_q     <= 4'd0;
        id_ex_src2_q     <= 4'd0;
        id_ex_rd_q       <= 4'd0;
        id_ex_regwrite_q <= 1'b0;
        id_ex_memread_q  <= 1'b0;
        id_ex_memwrite_q <= 1'b0;
      end else begin
        id_ex_src1_q     <= bus.ID_SrcReg1;
        id_ex_src2_q     <= bus.ID_SrcReg2;
        id_ex_rd_q       <= bus.ID_reg_rd;
        id_ex_regwrite_q <= bus.ID_RegWrite;
        id_ex_memread_q  <= bus.ID_MemRead;
        id_ex_memwrite_q <= bus.ID_MemWrite;
      end
      ex_mem_src2_q     <= id_ex_src2_q;
      ex_mem_rd_q       <= id_ex_rd_q;
      ex_mem_regwrite_q <= id_ex_regwrite_q;
      ex_mem_memread_q  <= id_ex_memread_q;
      mem_wb_rd_q       <= ex_mem_rd_q;
      mem_wb_regwrite_q <= ex_mem_regwrite_q;
    end
  end

  // Counters stick at all-ones instead of wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_count_q <= '0;
      flush_count_q <= '0;
    end else begin
      if (stall && (stall_count_q != '1)) begin
        stall_count_q <= stall_count_q + CNT_W'(1);
      end
      if (bus.Flush && (flush_count_q != '1)) begin
        flush_count_q <= flush_count_q + CNT_W'(1);
      end
    end
  end

  assign bus.ID_EX_SrcReg1   = id_ex_src1_q;
  assign bus.ID_EX_SrcReg2   = id_ex_src2_q;
  assign bus.ID_EX_reg_rd    = id_ex_rd_q;
  assign bus.ID_EX_RegWrite  = id_ex_regwrite_q;
  assign bus.ID_EX_MemRead   = id_ex_memread_q;
  assign bus.ID_EX_MemWrite  = id_ex_memwrite_q;
  assign bus.EX_MEM_SrcReg2  = ex_mem_src2_q;
  assign bus.EX_MEM_reg_rd   = ex_mem_rd_q;
  assign bus.EX_MEM_RegWrite = ex_mem_regwrite_q;
  assign bus.EX_MEM_MemRead  = ex_mem_memread_q;
  assign bus.MEM_WB_reg_rd   = mem_wb_rd_q;
  assign bus.MEM_WB_RegWrite = mem_wb_regwrite_q;
  assign bus.Stall           = stall;
  assign bus.stall_count     = stall_count_q;
  assign bus.flush_count     = flush_count_q;

endmodule

// File: tb/tb_dest_reg_pipeline.sv
// Self-checking bench for dest_reg_pipeline: directed scenarios plus randomized
// traffic compared against a history-queue reference model.
module tb_dest_reg_pipeline;
  localparam int CNT_W = 4;
  localparam int MAXC  = (1 << CNT_W) - 1;

  typedef struct packed {
    logic [3:0] s1;
    logic [3:0] s2;
    logic [3:0] rd;
    logic       u1;
    logic       u2;
    logic       rw;
    logic       mr;
    logic       mw;
  } ins_t;

  localparam ins_t BUBBLE = '0;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  // Entries that entered ID/EX, newest first: [0]=ID/EX, [1]=EX/MEM, [2]=MEM/WB.
  ins_t hist[$];
  int   exp_stall_cnt;
  int   exp_flush_cnt;

  dest_reg_if #(.CNT_W(CNT_W)) bus ();

  dest_reg_pipeline #(.CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [29:0] obs_vec;
  assign obs_vec = {bus.ID_EX_SrcReg1, bus.ID_EX_SrcReg2, bus.ID_EX_reg_rd,
                    bus.ID_EX_RegWrite, bus.ID_EX_MemRead, bus.ID_EX_MemWrite,
                    bus.EX_MEM_SrcReg2, bus.EX_MEM_reg_rd,
                    bus.EX_MEM_RegWrite, bus.EX_MEM_MemRead,
                    bus.MEM_WB_reg_rd, bus.MEM_WB_RegWrite};

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [29:0] exp_vec();
    return {hist[0].s1, hist[0].s2, hist[0].rd, hist[0].rw, hist[0].mr, hist[0].mw,
            hist[1].s2, hist[1].rd, hist[1].rw, hist[1].mr,
            hist[2].rd, hist[2].rw};
  endfunction

  function automatic logic model_lu(input ins_t ex, input ins_t id);
    return ex.mr && (ex.rd != 4'd0) &&
           ((id.u1 && ex.rd == id.s1) || (id.u2 && ex.rd == id.s2 && !id.mw));
  endfunction

  function automatic int sat_inc(input int v);
    return (v >= MAXC) ? MAXC : v + 1;
  endfunction

  task automatic model_reset();
    hist.delete();
    repeat (3) hist.push_back(BUBBLE);
    exp_stall_cnt = 0;
    exp_flush_cnt = 0;
  endtask

  function automatic ins_t mk(input int s1, input int s2, input int rd,
                              input bit u1, input bit u2, input bit rw,
                              input bit mr, input bit mw);
    ins_t t;
    t.s1 = 4'(s1); t.s2 = 4'(s2); t.rd = 4'(rd);
    t.u1 = u1; t.u2 = u2; t.rw = rw; t.mr = mr; t.mw = mw;
    return t;
  endfunction

  // driver: present decode inputs, sample Stall before the edge, advance the model
  task automatic drive(input ins_t ins, input logic flush,
                       output logic stall_obs, output logic stall_exp);
    bus.ID_SrcReg1  = ins.s1;
    bus.ID_SrcReg2  = ins.s2;
    bus.ID_reg_rd   = ins.rd;
    bus.ID_Uses1    = ins.u1;
    bus.ID_Uses2    = ins.u2;
    bus.ID_RegWrite = ins.rw;
    bus.ID_MemRead  = ins.mr;
    bus.ID_MemWrite = ins.mw;
    bus.Flush       = flush;
    #1;
    stall_obs = bus.Stall;
    stall_exp = model_lu(hist[0], ins) && !flush;
    @(posedge clk);
    if (stall_exp) exp_stall_cnt = sat_inc(exp_stall_cnt);
    if (flush)     exp_flush_cnt = sat_inc(exp_flush_cnt);
    hist.push_front((stall_exp || flush) ? BUBBLE : ins);
    void'(hist.pop_back());
    #1;
  endtask

  task automatic test_reset();
    logic so, se;
    if (obs_vec !== 30'd0 || bus.Stall !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_initial: outputs=%h stall=%b, required 0/0", obs_vec, bus.Stall);
    end
    n_checks++;
    if (bus.stall_count !== 4'd0 || bus.flush_count !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_counts: stall=%0d flush=%0d, required 0/0", bus.stall_count, bus.flush_count);
    end
    n_checks++;
    drive(mk(0, 0, 5, 0, 0, 1, 0, 0), 1'b0, so, se);
    drive(mk(0, 0, 6, 0, 0, 1, 0, 0), 1'b0, so, se);
    drive(mk(0, 0, 7, 0, 0, 1, 0, 0), 1'b0, so, se);
    if (bus.ID_EX_reg_rd !== 4'd7 || bus.EX_MEM_reg_rd !== 4'd6 || bus.MEM_WB_reg_rd !== 4'd5) begin
      n_fail++;
      $display("FAIL reset_fill: rd=%0d/%0d/%0d, required 7/6/5",
               bus.ID_EX_reg_rd, bus.EX_MEM_reg_rd, bus.MEM_WB_reg_rd);
    end
    n_checks++;
    #2 rst = 1'b1;
    #1;
    if (obs_vec !== 30'd0 || bus.Stall !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_async: outputs=%h stall=%b, required 0", obs_vec, bus.Stall);
    end
    n_checks++;
    @(posedge clk); #1;
    if (obs_vec !== 30'd0 || bus.stall_count !== 4'd0 || bus.flush_count !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_held: outputs=%h counts=%0d/%0d, required 0", obs_vec,
               bus.stall_count, bus.flush_count);
    end
    n_checks++;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_propagation();
    logic so, se;
    drive(mk(0, 9, 3, 0, 0, 1, 0, 0), 1'b0, so, se);
    if (bus.ID_EX_reg_rd !== 4'd3) begin
      n_fail++;
      $display("FAIL prop_id_ex: rd=%0d, required 3", bus.ID_EX_reg_rd);
    end
    n_checks++;
    drive(BUBBLE, 1'b0, so, se);
    if (bus.EX_MEM_reg_rd !== 4'd3 || bus.EX_MEM_SrcReg2 !== 4'd9) begin
      n_fail++;
      $display("FAIL prop_ex_mem: rd=%0d src2=%0d, required 3/9", bus.EX_MEM_reg_rd, bus.EX_MEM_SrcReg2);
    end
    n_checks++;
    drive(BUBBLE, 1'b0, so, se);
    if (bus.MEM_WB_reg_rd !== 4'd3 || bus.MEM_WB_RegWrite !== 1'b1) begin
      n_fail++;
      $display("FAIL prop_mem_wb: rd=%0d rw=%b, required 3/1", bus.MEM_WB_reg_rd, bus.MEM_WB_RegWrite);
    end
    n_checks++;
  endtask

  task automatic test_load_use();
    logic so, se;
    ins_t add_i;
    add_i = mk(4, 1, 5, 1, 1, 1, 0, 0);
    drive(BUBBLE, 1'b0, so, se);
    drive(mk(1, 0, 4, 1, 0, 1, 1, 0), 1'b0, so, se);
    drive(add_i, 1'b0, so, se);
    if (so !== 1'b1) begin
      n_fail++;
      $display("FAIL lu_stall: stall=%b, required 1", so);
    end
    n_checks++;
    if (bus.ID_EX_reg_rd !== 4'd0 || bus.ID_EX_MemRead !== 1'b0 || bus.ID_EX_RegWrite !== 1'b0) begin
      n_fail++;
      $display("FAIL lu_bubble: rd=%0d mr=%b rw=%b, required 0/0/0",
               bus.ID_EX_reg_rd, bus.ID_EX_MemRead, bus.ID_EX_RegWrite);
    end
    n_checks++;
    if (bus.stall_count !== 4'd1) begin
      n_fail++;
      $display("FAIL lu_count: stall_count=%0d, required 1", bus.stall_count);
    end
    n_checks++;
    drive(add_i, 1'b0, so, se);
    if (so !== 1'b0 || bus.ID_EX_reg_rd !== 4'd5 || bus.ID_EX_SrcReg1 !== 4'd4) begin
      n_fail++;
      $display("FAIL lu_advance: stall=%b rd=%0d src1=%0d, required 0/5/4",
               so, bus.ID_EX_reg_rd, bus.ID_EX_SrcReg1);
    end
    n_checks++;
  endtask

  task automatic test_store_exempt();
    logic so, se;
    drive(BUBBLE, 1'b0, so, se);
    drive(mk(1, 0, 4, 1, 0, 1, 1, 0), 1'b0, so, se);
    drive(mk(2, 4, 0, 1, 1, 0, 0, 1), 1'b0, so, se);
    if (so !== 1'b0) begin
      n_fail++;
      $display("FAIL sw_data_exempt: stall=%b, required 0", so);
    end
    n_checks++;
    drive(BUBBLE, 1'b0, so, se);
    drive(mk(1, 0, 4, 1, 0, 1, 1, 0), 1'b0, so, se);
    drive(mk(4, 3, 0, 1, 1, 0, 0, 1), 1'b0, so, se);
    if (so !== 1'b1) begin
      n_fail++;
      $display("FAIL sw_addr_stall: stall=%b, required 1", so);
    end
    n_checks++;
    drive(mk(4, 3, 0, 1, 1, 0, 0, 1), 1'b0, so, se);
  endtask

  task automatic test_reg0_flush();
    logic so, se;
    int sc;
    drive(BUBBLE, 1'b0, so, se);
    drive(mk(1, 0, 0, 1, 0, 1, 1, 0), 1'b0, so, se);
    drive(mk(0, 0, 5, 1, 0, 1, 0, 0), 1'b0, so, se);
    if (so !== 1'b0) begin
      n_fail++;
      $display("FAIL reg0_no_stall: stall=%b, required 0", so);
    end
    n_checks++;
    if (bus.ID_EX_reg_rd !== 4'd5) begin
      n_fail++;
      $display("FAIL reg0_advance: rd=%0d, required 5", bus.ID_EX_reg_rd);
    end
    n_checks++;
    drive(BUBBLE, 1'b0, so, se);
    drive(mk(1, 0, 4, 1, 0, 1, 1, 0), 1'b0, so, se);
    sc = exp_stall_cnt;
    drive(mk(4, 0, 5, 1, 0, 1, 0, 0), 1'b1, so, se);
    if (so !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_no_stall: stall=%b, required 0", so);
    end
    n_checks++;
    if (bus.flush_count !== 4'd1 || bus.stall_count !== 4'(sc)) begin
      n_fail++;
      $display("FAIL flush_counts: flush=%0d stall=%0d, required 1/%0d",
               bus.flush_count, bus.stall_count, sc);
    end
    n_checks++;
    if (bus.ID_EX_reg_rd !== 4'd0 || bus.ID_EX_RegWrite !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_bubble: rd=%0d rw=%b, required 0/0", bus.ID_EX_reg_rd, bus.ID_EX_RegWrite);
    end
    n_checks++;
  endtask

  task automatic test_back_to_back();
    logic so, se;
    int sc;
    ins_t lw_i, add_i;
    lw_i  = mk(1, 0, 4, 1, 0, 1, 1, 0);
    add_i = mk(4, 2, 6, 1, 1, 1, 0, 0);
    drive(BUBBLE, 1'b0, so, se);
    sc = exp_stall_cnt;
    for (int k = 0; k < 2; k++) begin
      drive(lw_i, 1'b0, so, se);
      drive(add_i, 1'b0, so, se);
      if (so !== 1'b1) begin
        n_fail++;
        $display("FAIL b2b_stall%0d: stall=%b, required 1", k, so);
      end
      n_checks++;
      drive(add_i, 1'b0, so, se);
      if (so !== 1'b0 || bus.ID_EX_reg_rd !== 4'd6) begin
        n_fail++;
        $display("FAIL b2b_release%0d: stall=%b rd=%0d, required 0/6", k, so, bus.ID_EX_reg_rd);
      end
      n_checks++;
    end
    if (int'(bus.stall_count) !== sc + 2) begin
      n_fail++;
      $display("FAIL b2b_count: stall_count=%0d, required %0d", bus.stall_count, sc + 2);
    end
    n_checks++;
  endtask

  task automatic test_saturation();
    logic so, se;
    for (int k = 0; k < 20; k++) begin
      drive(mk($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15),
               1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom)),
            1'b1, so, se);
      if (int'(bus.flush_count) !== exp_flush_cnt || so !== 1'b0) begin
        n_fail++;
        $display("FAIL sat_step%0d: flush_count=%0d stall=%b, required %0d/0",
                 k, bus.flush_count, so, exp_flush_cnt);
      end
      n_checks++;
    end
    if (bus.flush_count !== 4'd15) begin
      n_fail++;
      $display("FAIL sat_final: flush_count=%0d, required 15", bus.flush_count);
    end
    n_checks++;
  endtask

  task automatic test_random();
    logic so, se;
    ins_t cur;
    se = 1'b0;
    cur = BUBBLE;
    for (int k = 0; k < 300; k++) begin
      // A stalled decode instruction is re-presented, as the held IF/ID would do.
      if (!se) begin
        cur = mk($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                 1'($urandom), 1'($urandom), 1'($urandom),
                 ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0));
      end
      drive(cur, ($urandom_range(0, 7) == 0), so, se);
      if (so !== se) begin
        n_fail++;
        $display("FAIL rnd_stall%0d: stall=%b, required %b", k, so, se);
      end
      n_checks++;
      if (obs_vec !== exp_vec()) begin
        n_fail++;
        $display("FAIL rnd_fields%0d: outputs=%h, required %h", k, obs_vec, exp_vec());
      end
      n_checks++;
      if (int'(bus.stall_count) !== exp_stall_cnt || int'(bus.flush_count) !== exp_flush_cnt) begin
        n_fail++;
        $display("FAIL rnd_counts%0d: stall=%0d flush=%0d, required %0d/%0d", k,
                 bus.stall_count, bus.flush_count, exp_stall_cnt, exp_flush_cnt);
      end
      n_checks++;
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    bus.ID_SrcReg1  = 4'd0;
    bus.ID_SrcReg2  = 4'd0;
    bus.ID_reg_rd   = 4'd0;
    bus.ID_Uses1    = 1'b0;
    bus.ID_Uses2    = 1'b0;
    bus.ID_RegWrite = 1'b0;
    bus.ID_MemRead  = 1'b0;
    bus.ID_MemWrite = 1'b0;
    bus.Flush       = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    test_reset_hold_check();
    @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_propagation();
    test_load_use();
    test_store_exempt();
    test_reg0_flush();
    test_back_to_back();
    test_saturation();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  task automatic test_reset_hold_check();
    if (obs_vec !== 30'd0 || bus.Stall !== 1'b0 || bus.stall_count !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_power_on: outputs=%h stall=%b count=%0d, required 0",
               obs_vec, bus.Stall, bus.stall_count);
    end
    n_checks++;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach the end of the test");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/dest_reg_pipeline.md
# dest_reg_pipeline

Carries register-ID and write-control metadata through the ID/EX, EX/MEM and MEM/WB pipeline registers, producing the `EX_MEM_*`, `MEM_WB_*` and `ID_EX_*` fields that feed forwarding. It also detects load-use hazards against the instruction in decode, requests a one-cycle stall, and injects bubbles on stall or flush. It sits beside the datapath pipeline registers, between the decoder and the forwarding logic, and keeps saturating performance counters for stalls and flushes.

## Interface
- `CNT_W`, default 16: width of the stall and flush counters.

Ports:
- `clk` in 1: clock; all state changes on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `ID_SrcReg1` in 4: first source register of the decode instruction.
- `ID_SrcReg2` in 4: second source register of the decode instruction; store-data register for SW.
- `ID_reg_rd` in 4: destination register of the decode instruction.
- `ID_Uses1`, `ID_Uses2` in 1: decode instruction reads `SrcReg1` / `SrcReg2`.
- `ID_RegWrite`, `ID_MemRead`, `ID_MemWrite` in 1: decode controls.
- `Flush` in 1: wrong-path flush of the decode instruction (taken branch).
- `ID_EX_SrcReg1`, `ID_EX_SrcReg2`, `ID_EX_reg_rd` out 4: ID/EX fields.
- `ID_EX_RegWrite`, `ID_EX_MemRead`, `ID_EX_MemWrite` out 1: ID/EX controls.
- `EX_MEM_SrcReg2`, `EX_MEM_reg_rd` out 4: EX/MEM fields.
- `EX_MEM_RegWrite`, `EX_MEM_MemRead` out 1: EX/MEM controls.
- `MEM_WB_reg_rd` out 4: MEM/WB destination.
- `MEM_WB_RegWrite` out 1: MEM/WB write enable.
- `Stall` out 1: hold the PC and IF/ID (combinational).
- `stall_count`, `flush_count` out `CNT_W`: saturating event counters.

## Operation
- **Bubble:** all 4-bit fields are 0 and all controls are 0. A bubble is never a hazard source, because `reg_rd` = 0.
- **Load-use hazard (`LU`):** `LU = ID_EX_MemRead & (ID_EX_reg_rd != 0) & (A | B)`.
  - `A = ID_Uses1 & (ID_EX_reg_rd == ID_SrcReg1)`.
  - `B = ID_Uses2 & (ID_EX_reg_rd == ID_SrcReg2) & ~ID_MemWrite`.
  - A store whose only match is its data register (`SrcReg2`) does not stall; MEM-to-MEM forwarding covers it.
- `Stall = LU & ~Flush`. A flushed instruction is discarded, so it never stalls.
- **ID/EX load:**
  - On `Flush` or `Stall`, ID/EX loads a bubble.
  - Otherwise ID/EX loads the `ID_*` inputs.
- **Downstream registers:** EX/MEM ← ID/EX and MEM/WB ← EX/MEM every cycle, unconditionally.
  - `EX_MEM_SrcReg2` comes from `ID_EX_SrcReg2`.
  - `EX_MEM_MemRead` comes from `ID_EX_MemRead`.
- **Counters:**
  - `stall_count` increments by 1 on every edge with `Stall` = 1.
  - `flush_count` increments by 1 on every edge with `Flush` = 1.
  - Both saturate at all-ones, with no wrap.
- **Register 0 writes:** a decode instruction with `ID_RegWrite` = 1 and `ID_reg_rd` = 0 is carried unchanged. Suppressing it is not this block's job.

## Timing
- **Reset:** all pipeline fields, controls and counters are 0, so `Stall` = 0. Reset takes effect asynchronously, mid-stream included: in-flight entries become bubbles immediately.
- **Latency:** a decode instruction appears on the `ID_EX_*` outputs 1 cycle later, on `EX_MEM_*` 2 cycles later, and on `MEM_WB_*` 3 cycles later.
- **`Stall` timing:**
  - It is valid in the same cycle as the `ID_*` inputs and the current ID/EX contents.
  - It lasts exactly 1 cycle per load-use pair: after the edge, ID/EX holds a bubble, so `LU` falls.
  - The held decode instruction then advances on the next edge.
- **Back-to-back loads:** two loads to the same register, each followed by a dependent instruction, produce independent single-cycle stalls.
- **`Flush` with `LU`:** `Stall` = 0, a bubble is inserted, `flush_count` increments and `stall_count` does not.

## Test plan
- **Reset mid-stream:** fill all three stages with `rd` = 5/6/7, RegWrite = 1, then pulse `rst`. Required: every output reads 0 before the next edge, and stays 0 while `rst` is held.
- **Propagation:** issue `rd` = 3, RegWrite = 1, `Src2` = 9 with no hazards. Required:
  - `ID_EX_reg_rd` = 3 at cycle +1.
  - `EX_MEM_reg_rd` = 3 and `EX_MEM_SrcReg2` = 9 at cycle +2.
  - `MEM_WB_reg_rd` = 3 and `MEM_WB_RegWrite` = 1 at cycle +3.
- **Load-use:** LW `rd` = 4, then ADD with `Src1` = 4. Required: `Stall` = 1 for one cycle, ID/EX holds a bubble, the ADD enters ID/EX on the following edge, and `stall_count` = 1.
- **Store-data exemption:** LW `rd` = 4, then SW with `Src2` = 4, `Src1` = 2. Required: `Stall` = 0. Repeat with SW `Src1` = 4. Required: `Stall` = 1.
- **Register-0 and flush:**
  - LW `rd` = 0, then ADD with `Src1` = 0. Required: `Stall` = 0.
  - LW `rd` = 4, then ADD with `Src1` = 4 while `Flush` = 1. Required: `Stall` = 0, `flush_count` = 1, and ID/EX holds a bubble.
- **Saturation:** with `CNT_W` = 4, hold `Flush` for 20 cycles. Required: `flush_count` stops at 15 and does not wrap.
